// File: rtl/fp_round_pipe.sv
// fp_round_pipe: IEEE rounding (RNE/RTZ/RUP/RDN), carry renormalise and pack with overflow/inexact/zero flags.
// Two register stages, latency 2; valid/ready both sides, a stalled stage holds all of its state.
module fp_round_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W:0]          in_exp,
  input  logic [FRAC_W+3:0]       in_man,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic                    out_overflow,
  output logic                    out_inexact,
  output logic                    out_zero
);

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;

  logic en1, en2;

  // stage 1 state
  logic                s1_valid_q,   s1_valid_d;
  logic [FRAC_W+1:0]   s1_sum_q,     s1_sum_d;
  logic                s1_sign_q,    s1_sign_d;
  logic [EXP_W:0]      s1_exp_q,     s1_exp_d;
  logic [1:0]          s1_mode_q,    s1_mode_d;
  logic                s1_inexact_q, s1_inexact_d;
  logic                s1_hidden_q,  s1_hidden_d;

  // stage 2 (output) state
  logic                  out_valid_q,    out_valid_d;
  logic [EXP_W+FRAC_W:0] out_result_q,   out_result_d;
  logic                  out_overflow_q, out_overflow_d;
  logic                  out_inexact_q,  out_inexact_d;
  logic                  out_zero_q,     out_zero_d;

  logic              lsb, g, st, inc;
  logic [FRAC_W+1:0] sum;

  logic              carry, ovf, inf_sel;
  logic [EXP_W:0]    exp_adj;
  logic [FRAC_W-1:0] frac, frac_f;
  logic [EXP_W-1:0]  exp_f;

  assign en2      = ~out_valid_q | out_ready;
  assign en1      = ~s1_valid_q | en2;
  assign in_ready = en1;

  always_comb begin
    lsb = in_man[3];
    g   = in_man[2];
    st  = in_man[1] | in_man[0];
    case (in_mode)
      RNE:     inc = g & (st | lsb);
      RTZ:     inc = 1'b0;
      RUP:     inc = ~in_sign & (g | st);
      default: inc = in_sign & (g | st);
    endcase
    sum = {1'b0, in_man[FRAC_W+3:3]} + {{(FRAC_W+1){1'b0}}, inc};
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sum_d     = s1_sum_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_mode_d    = s1_mode_q;
    s1_inexact_d = s1_inexact_q;
    s1_hidden_d  = s1_hidden_q;
    if (en1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d     = sum;
        s1_sign_d    = in_sign;
        s1_exp_d     = in_exp;
        s1_mode_d    = in_mode;
        s1_inexact_d = g | st;
        s1_hidden_d  = in_man[FRAC_W+3];
      end
    end
  end

  always_comb begin
    carry = s1_sum_q[FRAC_W+1];
    frac  = s1_sum_q[FRAC_W-1:0];
    if (carry) begin
      frac    = s1_sum_q[FRAC_W:1];
      exp_adj = s1_exp_q + {{EXP_W{1'b0}}, 1'b1};
    end else if (!s1_hidden_q) begin
      // subnormal: rounding into the hidden position promotes it to the smallest normal
      exp_adj = {{EXP_W{1'b0}}, s1_sum_q[FRAC_W]};
    end else begin
      exp_adj = s1_exp_q;
    end
    ovf     = s1_exp_q[EXP_W] | (exp_adj >= {1'b0, {EXP_W{1'b1}}});
    inf_sel = (s1_mode_q == RNE) | ((s1_mode_q == RUP) & ~s1_sign_q) |
              ((s1_mode_q == RDN) & s1_sign_q);
    exp_f   = exp_adj[EXP_W-1:0];
    frac_f  = frac;
    if (ovf) begin
      if (inf_sel) begin
        exp_f  = {EXP_W{1'b1}};
        frac_f = {FRAC_W{1'b0}};
      end else begin
        exp_f  = {{(EXP_W-1){1'b1}}, 1'b0};
        frac_f = {FRAC_W{1'b1}};
      end
    end

    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_inexact_d  = out_inexact_q;
    out_zero_d     = out_zero_q;
    if (en2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d   = {s1_sign_q, exp_f, frac_f};
        out_overflow_d = ovf;
        out_inexact_d  = s1_inexact_q | ovf;
        out_zero_d     = (exp_f == '0) && (frac_f == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      s1_valid_q     <= 1'b0;
      s1_sum_q       <= '0;
      s1_sign_q      <= 1'b0;
      s1_exp_q       <= '0;
      s1_mode_q      <= '0;
      s1_inexact_q   <= 1'b0;
      s1_hidden_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_inexact_q  <= 1'b0;
      out_zero_q     <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_sum_q       <= s1_sum_d;
      s1_sign_q      <= s1_sign_d;
      s1_exp_q       <= s1_exp_d;
      s1_mode_q      <= s1_mode_d;
      s1_inexact_q   <= s1_inexact_d;
      s1_hidden_q    <= s1_hidden_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_inexact_q  <= out_inexact_d;
      out_zero_q     <= out_zero_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_overflow = out_overflow_q;
  assign out_inexact  = out_inexact_q;
  assign out_zero     = out_zero_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: directed IEEE cases, back-pressure, async reset, then random traffic
// against an arithmetic reference model with an in-order scoreboard.
module tb_fp_round_pipe;

  logic        clk = 1'b0;
  logic        res;
  logic        in_valid, in_ready, in_sign;
  logic [8:0]  in_exp;
  logic [26:0] in_man;
  logic [1:0]  in_mode;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_overflow, out_inexact, out_zero;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int acc_cnt = 0;
  logic        rdy_seen;
  logic [34:0] last_out;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  fp_round_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .res(res),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_man(in_man), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_inexact(out_inexact), .out_zero(out_zero)
  );

  // Reference: integer rounding of the 24-bit significand by its 3 trailing bits.
  function automatic logic [34:0] model(input logic s, input logic [8:0] e,
                                        input logic [26:0] m, input logic [1:0] md);
    int unsigned trunc, rem, q, ee, f;
    bit up, ovf, inf;
    logic [31:0] r;
    trunc = int'(m) >> 3;
    rem   = int'(m) % 8;
    case (md)
      2'd0:    up = (rem > 4) || (rem == 4 && trunc % 2 == 1);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && rem != 0;
      default: up = s && rem != 0;
    endcase
    q = trunc + (up ? 1 : 0);
    if (m[26]) begin
      if (q == (1 << 24)) begin ee = e + 1; f = 0; end
      else begin ee = e; f = q % (1 << 23); end
      ovf = (e >= 256) || (ee >= 255);
    end else begin
      ee  = q >> 23;
      f   = q % (1 << 23);
      ovf = (e >= 256);
    end
    if (ovf) begin
      inf = (md == 2'd0) || (md == 2'd2 && !s) || (md == 2'd3 && s);
      r = inf ? {s, 8'hFF, 23'h000000} : {s, 8'hFE, 23'h7FFFFF};
    end else begin
      r = {s, ee[7:0], f[22:0]};
    end
    return {r, ovf, (rem != 0) || ovf, r[30:0] == 31'd0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at negedge, sample handshakes 1ns later, transfers happen at next posedge.
  task automatic cyc(input bit v, input logic s, input logic [8:0] e, input logic [26:0] m,
                     input logic [1:0] md, input bit ordy);
    logic [34:0] got;
    @(negedge clk);
    in_valid = v; in_sign = s; in_exp = e; in_man = m; in_mode = md; out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    if (out_valid && out_ready) begin
      got = {out_result, out_overflow, out_inexact, out_zero};
      n_out++;
      last_out = got;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_out observed %h expected no output", got);
      end
      if (exp_q.size() > 0) chk("scoreboard", 64'(got), 64'(exp_q.pop_front()));
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(s, e, m, md));
      acc_cnt++;
    end
  endtask

  task automatic dir(input string tag, input logic s, input logic [8:0] e, input logic [26:0] m,
                     input logic [1:0] md, input logic [31:0] er, input bit eo, input bit ei,
                     input bit ez);
    int n0;
    n0 = n_out;
    cyc(1'b1, s, e, m, md, 1'b1);
    for (int k = 0; k < 10 && n_out == n0; k++) cyc(1'b0, 1'b0, 9'd0, 27'd0, 2'd0, 1'b1);
    checks++;
    assert (n_out != n0) else begin
      errors++;
      $error("FAIL %s_timeout observed no output expected one within 10 cycles", tag);
    end
    if (n_out != n0) chk(tag, 64'(last_out), 64'({er, eo, ei, ez}));
  endtask

  initial begin
    int a0, n0;
    res = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0; in_mode = '0;
    out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_word", 64'({out_result, out_overflow, out_inexact, out_zero}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    res = 1'b1;

    dir("tie_rne_odd",  0, 9'h07F, {1'b1, 23'h000001, 3'b100}, 2'd0, 32'h3F800002, 0, 1, 0);
    dir("tie_rne_even", 0, 9'h07F, {1'b1, 23'h000000, 3'b100}, 2'd0, 32'h3F800000, 0, 1, 0);
    dir("carry_renorm", 0, 9'h07F, {1'b1, 23'h7FFFFF, 3'b100}, 2'd0, 32'h40000000, 0, 1, 0);
    dir("ovf_rne",      0, 9'h0FE, {1'b1, 23'h7FFFFF, 3'b110}, 2'd0, 32'h7F800000, 1, 1, 0);
    dir("noovf_rtz",    0, 9'h0FE, {1'b1, 23'h7FFFFF, 3'b110}, 2'd1, 32'h7F7FFFFF, 0, 1, 0);
    dir("ovf_up_rtz",   1, 9'h1FE, {1'b1, 23'h7FFFFF, 3'b110}, 2'd1, 32'hFF7FFFFF, 1, 1, 0);
    dir("rup_pos",      0, 9'h07F, {1'b1, 23'h000000, 3'b001}, 2'd2, 32'h3F800001, 0, 1, 0);
    dir("rdn_pos",      0, 9'h07F, {1'b1, 23'h000000, 3'b001}, 2'd3, 32'h3F800000, 0, 1, 0);
    dir("rdn_neg",      1, 9'h07F, {1'b1, 23'h000000, 3'b001}, 2'd3, 32'hBF800001, 0, 1, 0);
    dir("neg_zero",     1, 9'h000, 27'd0, 2'd0, 32'h80000000, 0, 0, 1);
    dir("subnorm_up",   0, 9'h000, {1'b0, 23'h7FFFFF, 3'b100}, 2'd0, 32'h00800000, 0, 1, 0);
    dir("ovf_rup_neg",  1, 9'h0FF, {1'b1, 23'h000000, 3'b000}, 2'd2, 32'hFF7FFFFF, 1, 1, 0);

    // back-pressure: third word must be refused while both stages are held
    a0 = acc_cnt; n0 = n_out;
    cyc(1'b1, 0, 9'h080, {1'b1, 23'h123456, 3'b011}, 2'd0, 1'b0);
    cyc(1'b1, 1, 9'h081, {1'b1, 23'h654321, 3'b101}, 2'd2, 1'b0);
    cyc(1'b1, 0, 9'h082, {1'b1, 23'h0ABCDE, 3'b111}, 2'd3, 1'b0);
    chk("bp_in_ready_low", 64'(rdy_seen), 64'd0);
    chk("bp_accepted", 64'(acc_cnt - a0), 64'd2);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 0, 9'h082, {1'b1, 23'h0ABCDE, 3'b111}, 2'd3, 1'b0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_word", 64'({out_result, out_overflow, out_inexact, out_zero}),
          64'(exp_q[0]));
    end
    for (int k = 0; k < 12; k++)
      cyc(acc_cnt < a0 + 3, 0, 9'h082, {1'b1, 23'h0ABCDE, 3'b111}, 2'd3, 1'b1);
    chk("bp_out_count", 64'(n_out - n0), 64'd3);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // asynchronous reset with two words in flight
    cyc(1'b1, 0, 9'h070, {1'b1, 23'h111111, 3'b000}, 2'd0, 1'b0);
    cyc(1'b1, 1, 9'h071, {1'b1, 23'h222222, 3'b000}, 2'd0, 1'b0);
    cyc(1'b0, 0, 9'h000, 27'd0, 2'd0, 1'b0);
    chk("pre_reset_full", 64'({out_valid, in_ready}), 64'b10);
    #2 res = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_result", 64'(out_result), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    res = 1'b1;
    n0 = n_out;
    for (int k = 0; k < 5; k++) cyc(1'b0, 0, 9'h000, 27'd0, 2'd0, 1'b1);
    chk("no_stale_output", 64'(n_out - n0), 64'd0);

    // random traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      logic [8:0] e;
      e = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(9'h0FC, 9'h101))
                                      : 9'($urandom_range(0, 511));
      cyc($urandom_range(0, 9) < 7, 1'($urandom), e, 27'($urandom), 2'($urandom),
          $urandom_range(0, 9) < 7);
    end
    for (int k = 0; k < 10; k++) cyc(1'b0, 0, 9'h000, 27'd0, 2'd0, 1'b1);
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
